noc_traffic_ctrl: RTL and testbench

NOC_TRAFFIC_CTRL -- requirements
Module: noc_traffic_ctrl

---
 rtl/noc_traffic_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_noc_traffic_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_ctrl.sv
// Traffic generator for a NoC under test: every node injects LIMIT packets, one per PERIOD ticks,
// then the block waits for every packet to be delivered or gives up after DRAIN_TO cycles.
module noc_traffic_ctrl #(
  parameter int NODES    = 16,
  parameter int DEST_W   = 4,
  parameter int PERIOD   = 8,
  parameter int LIMIT    = 4,
  parameter int DRAIN_TO = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NODES-1:0]               net_en,
  input  logic [NODES-1:0]               net_rx_val,
  output logic [NODES-1:0]               inj_val,
  output logic [NODES-1:0][DEST_W-1:0]   inj_dest,
  output logic [NODES-1:0][DEST_W-1:0]   inj_src,
  output logic [NODES-1:0][7:0]          inj_seq,
  output logic [15:0]                    tx_total,
  output logic [15:0]                    rx_total,
  output logic [3:0]                     led
);

  localparam int DCW = $clog2(DRAIN_TO) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   led_q, led_d;
  logic [7:0]                   pcnt_q, pcnt_d;
  logic [DCW-1:0]               dcnt_q, dcnt_d;
  logic [NODES-1:0]             inj_val_q, inj_val_d;
  logic [NODES-1:0][DEST_W-1:0] inj_dest_q, inj_dest_d;
  logic [NODES-1:0][7:0]        inj_seq_q, inj_seq_d;
  logic [NODES-1:0][7:0]        sent_q, sent_d;
  logic [NODES-1:0][7:0]        lfsr_q, lfsr_d;
  logic [15:0]                  tx_q, tx_d;
  logic [15:0]                  rx_q, rx_d;
  logic [NODES-1:0]             accept;
  logic                         tick;
  logic                         all_sent;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // A node never addresses itself; a self-hit is bumped to the next node.
  function automatic logic [DEST_W-1:0] gen_dest(input int node, input logic [DEST_W-1:0] lsb);
    int v;
    v = int'(lsb) % NODES;
    if (v == node) v = (node + 1) % NODES;
    return DEST_W'(v);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [NODES-1:0] v);
    logic [16:0] s;
    s = {1'b0, a};
    for (int k = 0; k < NODES; k++) s = s + {16'd0, v[k]};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [3:0] led_decode(input state_t s);
    case (s)
      S_RUN:   return 4'b0001;
      S_DRAIN: return 4'b0010;
      S_DONE:  return 4'b0100;
      S_ERR:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    dcnt_d     = dcnt_q;
    inj_val_d  = inj_val_q;
    inj_dest_d = inj_dest_q;
    inj_seq_d  = inj_seq_q;
    sent_d     = sent_q;
    lfsr_d     = lfsr_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    accept     = inj_val_q & net_en;
    tick       = 1'b0;
    all_sent   = 1'b1;
    for (int i = 0; i < NODES; i++) begin
      if (sent_q[i] != 8'(LIMIT)) all_sent = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_RUN;
          pcnt_d    = '0;
          dcnt_d    = '0;
          tx_d      = '0;
          rx_d      = '0;
          inj_seq_d = '0;
          sent_d    = '0;
        end
      end
      S_RUN: begin
        tick   = (pcnt_q == 8'(PERIOD - 1));
        pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        tx_d   = sat_add(tx_q, accept);
        rx_d   = sat_add(rx_q, net_rx_val);
        for (int i = 0; i < NODES; i++) begin
          if (accept[i]) begin
            inj_val_d[i] = 1'b0;
            inj_seq_d[i] = inj_seq_q[i] + 8'd1;
            sent_d[i]    = sent_q[i] + 8'd1;
          end
          // A node still holding an unaccepted packet simply misses this tick.
          if (tick && !inj_val_q[i] && (sent_q[i] < 8'(LIMIT))) begin
            inj_val_d[i]  = 1'b1;
            lfsr_d[i]     = lfsr_step(lfsr_q[i]);
            inj_dest_d[i] = gen_dest(i, lfsr_d[i][DEST_W-1:0]);
          end
        end
        if (all_sent && (inj_val_q == '0)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        rx_d = sat_add(rx_q, net_rx_val);
        if (rx_q == tx_q) begin
          state_d = S_DONE;
        end else if (dcnt_q == DCW'(DRAIN_TO - 1)) begin
          state_d = S_ERR;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    led_d = led_decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      pcnt_q     <= '0;
      dcnt_q     <= '0;
      inj_val_q  <= '0;
      inj_dest_q <= '0;
      inj_seq_q  <= '0;
      sent_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      for (int i = 0; i < NODES; i++) lfsr_q[i] <= 8'hA5 ^ 8'(i);
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      pcnt_q     <= pcnt_d;
      dcnt_q     <= dcnt_d;
      inj_val_q  <= inj_val_d;
      inj_dest_q <= inj_dest_d;
      inj_seq_q  <= inj_seq_d;
      sent_q     <= sent_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      lfsr_q     <= lfsr_d;
    end
  end

  for (genvar g = 0; g < NODES; g++) begin : g_src
    assign inj_src[g] = DEST_W'(g);
  end

  assign inj_val  = inj_val_q;
  assign inj_dest = inj_dest_q;
  assign inj_seq  = inj_seq_q;
  assign tx_total = tx_q;
  assign rx_total = rx_q;
  assign led      = led_q;

endmodule

// File: tb/tb_noc_traffic_ctrl.sv
// Bench for noc_traffic_ctrl: per-node expected packets are queued at each run start and
// popped by a negedge monitor on every accepted handshake.
module tb_noc_traffic_ctrl;
  localparam int NODES = 4, DEST_W = 4, PERIOD = 8, LIMIT = 4, DRAIN_TO = 64;

  logic clk = 1'b0;
  logic reset, start;
  logic [NODES-1:0] net_en, net_rx_val;
  logic [NODES-1:0] inj_val;
  logic [NODES-1:0][DEST_W-1:0] inj_dest, inj_src;
  logic [NODES-1:0][7:0] inj_seq;
  logic [15:0] tx_total, rx_total;
  logic [3:0] led;

  noc_traffic_ctrl #(.NODES(NODES), .DEST_W(DEST_W), .PERIOD(PERIOD), .LIMIT(LIMIT),
                     .DRAIN_TO(DRAIN_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .net_en(net_en), .net_rx_val(net_rx_val),
    .inj_val(inj_val), .inj_dest(inj_dest), .inj_src(inj_src), .inj_seq(inj_seq),
    .tx_total(tx_total), .rx_total(rx_total), .led(led));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic in_run = 1'b0, echo_en = 1'b0;
  logic [NODES-1:0] idle_rx = '0, acc_last = '0;
  logic [NODES-1:0] pipe [3];
  int exp_q [NODES][$];
  logic [7:0] m_lfsr [NODES];
  int exp_tx = 0, exp_rx = 0, cyc = 0, quad_cnt = 0;
  logic first0 = 1'b1;
  logic [NODES-1:0] prev_val = '0, prev_acc = '0;
  logic [DEST_W-1:0] prev_dest [NODES];
  logic [7:0] prev_seq [NODES];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, expv);
    end
  endtask

  // Reference rules: x^8+x^6+x^5+x^4+1 shift-left generator, destination = LSBs mod NODES, never self.
  function automatic logic [7:0] m_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int m_dest(input int node, input logic [7:0] s);
    int d;
    d = (int'(s) % (1 << DEST_W)) % NODES;
    if (d == node) d = (node + 1) % NODES;
    return d;
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [NODES-1:0] acc;
    int e;
    for (int i = 0; i < NODES; i++) begin
      m_lfsr[i] = 8'hA5 ^ 8'(i);
      prev_dest[i] = '0;
      prev_seq[i] = '0;
    end
    forever begin
      @(negedge clk);
      acc = inj_val & net_en;
      chk("tx_total", int'(tx_total), exp_tx);
      chk("rx_total", int'(rx_total), exp_rx);
      if (reset) begin
        for (int i = 0; i < NODES; i++) begin
          m_lfsr[i] = 8'hA5 ^ 8'(i);
          exp_q[i].delete();
        end
        exp_tx = 0;
        exp_rx = 0;
        first0 = 1'b1;
        acc = '0;
      end else begin
        if (start && !in_run) begin
          exp_tx = 0;
          exp_rx = 0;
          cyc = -1;
          for (int i = 0; i < NODES; i++) begin
            for (int k = 0; k < LIMIT; k++) begin
              m_lfsr[i] = m_step(m_lfsr[i]);
              exp_q[i].push_back(k * 256 + m_dest(i, m_lfsr[i]));
            end
          end
        end else begin
          cyc++;
        end
        for (int i = 0; i < NODES; i++) begin
          if (inj_val[i] && !prev_val[i])
            chk($sformatf("gen_on_tick_n%0d", i), int'(cyc > 0 && (cyc % PERIOD) == 0), 1);
          if (prev_val[i] && !prev_acc[i]) begin
            chk($sformatf("hold_val_n%0d", i), int'(inj_val[i]), 1);
            chk($sformatf("hold_dest_n%0d", i), int'(inj_dest[i]), int'(prev_dest[i]));
            chk($sformatf("hold_seq_n%0d", i), int'(inj_seq[i]), int'(prev_seq[i]));
          end
          if (acc[i]) begin
            chk($sformatf("pkt_expected_n%0d", i), int'(exp_q[i].size() > 0), 1);
            if (exp_q[i].size() > 0) begin
              e = exp_q[i].pop_front();
              chk($sformatf("pkt_dest_n%0d", i), int'(inj_dest[i]), e % 256);
              chk($sformatf("pkt_seq_n%0d", i), int'(inj_seq[i]), e / 256);
              chk($sformatf("pkt_src_n%0d", i), int'(inj_src[i]), i);
            end
            if (i == 0 && first0) begin
              chk("node0_first_dest", int'(inj_dest[0]), 2);
              first0 = 1'b0;
            end
          end
        end
        if (acc == '1) quad_cnt++;
        exp_tx += $countones(acc);
        if (in_run) exp_rx += $countones(net_rx_val);
      end
      prev_val = reset ? '0 : inj_val;
      prev_acc = acc;
      for (int i = 0; i < NODES; i++) begin
        prev_dest[i] = inj_dest[i];
        prev_seq[i] = inj_seq[i];
      end
      acc_last = acc;
    end
  end

  // Network model: delivers every accepted packet a few cycles later when echo is enabled.
  initial begin
    net_rx_val = '0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    forever begin
      @(posedge clk);
      #2;
      net_rx_val = echo_en ? pipe[2] : idle_rx;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = acc_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    in_run = 1'b1;
  endtask

  // mode 0: network always accepts; 1: random accept with a 20-cycle stall of node 2 and a
  // stray start pulse mid-run; 2: random accept.
  task automatic run_loop(input int mode, output logic [3:0] fin, output int drain_cyc);
    int hold_left;
    bit hold_done;
    hold_left = 0;
    hold_done = 1'b0;
    fin = '0;
    drain_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (led == 4'b0100 || led == 4'b1000) begin
        fin = led;
        break;
      end
      if (led == 4'b0010) drain_cyc++;
      if (mode == 0) begin
        net_en = '1;
      end else begin
        net_en = NODES'($urandom);
        if (mode == 1) begin
          if (hold_left > 0) chk("stall_inj_val2", int'(inj_val[2]), 1);
          if (!hold_done && inj_val[2]) begin
            hold_left = 20;
            hold_done = 1'b1;
          end
          if (hold_left > 0) begin
            net_en[2] = 1'b0;
            hold_left--;
          end
          start = (c == 30);
        end
      end
      step();
    end
    start = 1'b0;
    chk("run_finished", int'(fin != 4'b0000), 1);
    in_run = 1'b0;
    net_en = '0;
  endtask

  task automatic check_done(input string tag, input logic [3:0] fin);
    chk({tag, "_end_led"}, int'(fin), 4);
    chk({tag, "_led"}, int'(led), 4);
    chk({tag, "_tx"}, int'(tx_total), NODES * LIMIT);
    chk({tag, "_rx"}, int'(rx_total), NODES * LIMIT);
    for (int i = 0; i < NODES; i++) chk({tag, "_queue_empty"}, exp_q[i].size(), 0);
  endtask

  initial begin
    logic [3:0] fin;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    net_en = '0;
    repeat (3) step();
    chk("reset_led", int'(led), 0);
    chk("reset_inj_val", int'(inj_val), 0);
    chk("reset_inj_dest", int'(inj_dest), 0);
    chk("reset_inj_seq", int'(inj_seq), 0);
    chk("reset_tx", int'(tx_total), 0);
    chk("reset_rx", int'(rx_total), 0);
    chk("inj_src_n3_in_reset", int'(inj_src[3]), 3);
    reset = 1'b0;

    // Deliveries outside RUN/DRAIN are ignored
    for (int k = 0; k < 6; k++) begin
      idle_rx = NODES'($urandom) | 4'b0001;
      step();
    end
    idle_rx = '0;
    step();
    step();
    chk("idle_rx_ignored", int'(rx_total), 0);
    chk("idle_led", int'(led), 0);

    // All nodes always accepted
    echo_en = 1'b1;
    do_start();
    run_loop(0, fin, dc);
    check_done("runA", fin);
    chk("four_accepted_same_cycle", int'(quad_cnt > 0), 1);

    // Random accept, node 2 stalled, stray start
    do_start();
    run_loop(1, fin, dc);
    check_done("runB", fin);

    // Nothing delivered: drain times out
    echo_en = 1'b0;
    do_start();
    run_loop(0, fin, dc);
    chk("err_end_led", int'(fin), 8);
    chk("err_led", int'(led), 8);
    chk("err_drain_cycles", dc, DRAIN_TO);
    chk("err_tx", int'(tx_total), NODES * LIMIT);
    chk("err_rx", int'(rx_total), 0);
    echo_en = 1'b1;
    do_start();
    chk("restart_tx_cleared", int'(tx_total), 0);
    chk("restart_rx_cleared", int'(rx_total), 0);
    chk("restart_led_run", int'(led), 1);
    run_loop(2, fin, dc);
    check_done("runC", fin);

    // Reset mid-RUN with start asserted at the same edge
    net_en = '0;
    do_start();
    for (int k = 0; k < 40; k++) begin
      if ($countones(inj_val) >= 3) break;
      step();
    end
    chk("three_pending", int'($countones(inj_val) >= 3), 1);
    reset = 1'b1;
    start = 1'b1;
    in_run = 1'b0;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("midrun_reset_inj_val", int'(inj_val), 0);
    chk("midrun_reset_inj_dest", int'(inj_dest), 0);
    chk("midrun_reset_inj_seq", int'(inj_seq), 0);
    chk("midrun_reset_tx", int'(tx_total), 0);
    chk("midrun_reset_led", int'(led), 0);
    repeat (3) step();
    chk("midrun_reset_stays_idle", int'(led), 0);

    // Fresh run after reset restarts the generators from their seeds
    do_start();
    run_loop(2, fin, dc);
    check_done("runD", fin);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
